// File: rtl/board_io_pkg.sv
// Width and paging helpers shared by board_status_io and its debouncers.
package board_io_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Counter wide enough to hold the value c itself.
  function automatic int cnt_w(input int c);
    return clog2(c + 1);
  endfunction

  function automatic int num_pages(input int ios, input int base, input int w);
    if (ios <= base) return 1;
    return (ios - base + w - 1) / w;
  endfunction

  function automatic int page_w(input int np);
    int c;
    c = clog2(np);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; dout follows din once
// the synchronised value has differed from dout for DEBOUNCE_CYCLES cycles.
module debounce_sync
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic CLK,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      dout  <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      // Any return to the current output value restarts the stability count.
      if (r_s2 == dout) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        dout  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_status_io.sv
// Board pins <-> fabric: switch debounce, heartbeat, rx-activity stretch, paged LED window.
// Define BOARD_IO_PAGE_EN to enable the button-driven page select.
module board_status_io
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int NUM_LED         = 8,
  parameter int NUM_USED_IOS    = 16,
  parameter int LED_BASE        = 9,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int STRETCH_CYCLES  = 2000000,
  parameter int CTR_WIDTH       = 30,
  parameter int HEARTBEAT_BIT   = 25,
  localparam int W              = NUM_LED - 2,
  localparam int NUM_PAGES      = num_pages(NUM_USED_IOS, LED_BASE, W),
  localparam int PAGE_W         = page_w(NUM_PAGES)
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [NUM_SW-1:0]       sw,
  input  logic                    btn,
  input  logic                    rx_activity,
  input  logic                    com_active,
  input  logic [NUM_USED_IOS-1:0] I_top,
  output logic [NUM_SW-1:0]       sw_db,
  output logic [NUM_LED-1:0]      led,
  output logic [PAGE_W-1:0]       page
);

  localparam int STR_W = cnt_w(STRETCH_CYCLES);

  logic                 r_rx_s1, r_rx_s2;
  logic                 r_com_s1, r_com_s2;
  logic [CTR_WIDTH-1:0] r_ctr, w_ctr_nxt;
  logic [STR_W-1:0]     r_stretch, w_stretch_nxt;
  logic [NUM_LED-1:0]   r_led, w_led_nxt;
  logic [W-1:0]         w_win;
  logic [31:0]          w_off;
  logic                 w_hb;
  logic [PAGE_W-1:0]    w_page;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
      .CLK    (CLK),
      .resetn (resetn),
      .din    (sw[i]),
      .dout   (sw_db[i])
    );
  end

`ifdef BOARD_IO_PAGE_EN
  logic              w_btn_db;
  logic              r_btn_q;
  logic [PAGE_W-1:0] r_page;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (btn),
    .dout   (w_btn_db)
  );

  // Edge tracker keeps running during configuration so presses are dropped, not queued.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_btn_q <= 1'b0;
      r_page  <= '0;
    end else begin
      r_btn_q <= w_btn_db;
      if (w_btn_db && !r_btn_q && !r_com_s2)
        r_page <= (r_page == PAGE_W'(NUM_PAGES - 1)) ? '0 : r_page + PAGE_W'(1);
    end
  end

  assign w_page = r_page;
`else
  logic w_unused_btn;
  assign w_unused_btn = btn;
  assign w_page       = '0;
`endif

  assign page  = w_page;
  assign w_off = 32'(LED_BASE) + 32'(w_page) * 32'(W);
  // Zero padding above I_top makes out-of-range window bits read 0.
  assign w_win = W'({{W{1'b0}}, I_top} >> w_off);

  always_comb begin
    w_ctr_nxt     = r_ctr + CTR_WIDTH'(1);
    w_stretch_nxt = r_stretch;
    if (r_rx_s2)
      w_stretch_nxt = STR_W'(STRETCH_CYCLES);
    else if (r_stretch != '0)
      w_stretch_nxt = r_stretch - STR_W'(1);
    w_hb                   = w_ctr_nxt[HEARTBEAT_BIT];
    w_led_nxt              = '0;
    w_led_nxt[0]           = w_hb;
    w_led_nxt[1]           = (w_stretch_nxt != '0);
    w_led_nxt[NUM_LED-1:2] = r_com_s2 ? {W{w_hb}} : w_win;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1   <= 1'b0;
      r_rx_s2   <= 1'b0;
      r_com_s1  <= 1'b0;
      r_com_s2  <= 1'b0;
      r_ctr     <= '0;
      r_stretch <= '0;
      r_led     <= '0;
    end else begin
      r_rx_s1   <= rx_activity;
      r_rx_s2   <= r_rx_s1;
      r_com_s1  <= com_active;
      r_com_s2  <= r_com_s1;
      r_ctr     <= w_ctr_nxt;
      r_stretch <= w_stretch_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_board_status_io.sv
// Scoreboard bench for board_status_io: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_board_status_io;

  localparam int S_LED = 0;
  localparam int S_SW  = 1;
  localparam int S_PG  = 2;
`ifdef BOARD_IO_PAGE_EN
  localparam logic [7:0] EXP_P1 = 8'h01;
  localparam logic [7:0] EXP_W1 = 8'h04;
`else
  localparam logic [7:0] EXP_P1 = 8'h00;
  localparam logic [7:0] EXP_W1 = 8'h54;
`endif

  logic        CLK = 1'b0;
  logic        resetn;
  logic [1:0]  sw;
  logic        btn;
  logic        rx_activity;
  logic        com_active;
  logic [15:0] I_top;
  logic [1:0]  sw_db;
  logic [7:0]  led;
  logic [0:0]  page;

  board_status_io #(
    .DEBOUNCE_CYCLES (4),
    .STRETCH_CYCLES  (8),
    .CTR_WIDTH       (6),
    .HEARTBEAT_BIT   (2)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .sw          (sw),
    .btn         (btn),
    .rx_activity (rx_activity),
    .com_active  (com_active),
    .I_top       (I_top),
    .sw_db       (sw_db),
    .led         (led),
    .page        (page)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] mask;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         rel_cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mon_act;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        case (q[i].sel)
          S_LED:   mon_act = led;
          S_SW:    mon_act = {6'b0, sw_db};
          default: mon_act = 8'(page);
        endcase
        checks++;
        if ((mon_act & q[i].mask) !== (q[i].val & q[i].mask)) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h mask=%h",
                   q[i].name, cyc, mon_act, q[i].val, q[i].mask);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic exp_at(input int d, input int sel, input logic [7:0] mask,
                        input logic [7:0] val, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.name = nm;
    q.push_back(e);
  endtask

  // Heartbeat LED expected at observation cycle c: bit 2 of cycles since reset release.
  function automatic logic hb_at(input int c);
    return ((c - rel_cyc) & 4) != 0;
  endfunction

  initial begin
    resetn = 1'b0; sw = 2'b11; btn = 1'b0; rx_activity = 1'b1;
    com_active = 1'b0; I_top = 16'hAAAA;
    tick(2);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL rst_led_direct actual=%h", led);
    end
    checks++;
    if (sw_db !== 2'b00) begin
      errors++;
      $display("FAIL rst_sw_db_direct actual=%b", sw_db);
    end
    checks++;
    if (page !== 1'b0) begin
      errors++;
      $display("FAIL rst_page_direct actual=%b", page);
    end
    exp_at(1, S_LED, 8'hFF, 8'h00, "rst_led");
    exp_at(1, S_SW,  8'h03, 8'h00, "rst_sw_db");
    exp_at(1, S_PG,  8'hFF, 8'h00, "rst_page");
    tick(2);
    resetn  = 1'b1;
    rel_cyc = cyc;
    exp_at(5, S_SW,  8'h03, 8'h00, "swdb_lat_pre");
    exp_at(6, S_SW,  8'h03, 8'h03, "swdb_lat");
    exp_at(2, S_LED, 8'h02, 8'h00, "rx_rise_pre");
    exp_at(3, S_LED, 8'h02, 8'h02, "rx_rise");
    exp_at(1, S_LED, 8'hFC, 8'h54, "win_p0");
    for (int d = 1; d <= 8; d++)   exp_at(d, S_LED, 8'h01, {7'b0, hb_at(cyc + d)}, "hb");
    for (int d = 58; d <= 70; d++) exp_at(d, S_LED, 8'h01, {7'b0, hb_at(cyc + d)}, "hb_wrap");
    tick(8);

    // Receive stretch: fall after steady high, then two retriggering pulses.
    rx_activity = 1'b0;
    exp_at(9,  S_LED, 8'h02, 8'h02, "rx_hold_end");
    exp_at(10, S_LED, 8'h02, 8'h00, "rx_fall");
    tick(14);
    rx_activity = 1'b1;
    exp_at(2,  S_LED, 8'h02, 8'h00, "pulse_pre");
    exp_at(3,  S_LED, 8'h02, 8'h02, "pulse_rise");
    exp_at(10, S_LED, 8'h02, 8'h02, "pulse_held");
    exp_at(11, S_LED, 8'h02, 8'h02, "pulse_ext");
    exp_at(15, S_LED, 8'h02, 8'h02, "pulse2_end");
    exp_at(16, S_LED, 8'h02, 8'h00, "pulse2_fall");
    tick(1); rx_activity = 1'b0;
    tick(4); rx_activity = 1'b1;
    tick(1); rx_activity = 1'b0;
    tick(16);

    // Switch debounce: clean fall, short glitch, held press.
    sw = 2'b00;
    exp_at(5, S_SW, 8'h03, 8'h03, "sw_fall_pre");
    exp_at(6, S_SW, 8'h03, 8'h00, "sw_fall");
    tick(10);
    sw = 2'b01;
    for (int d = 3; d <= 10; d++) exp_at(d, S_SW, 8'h01, 8'h00, "glitch");
    tick(3); sw = 2'b00;
    tick(10);
    sw = 2'b01;
    exp_at(5, S_SW, 8'h01, 8'h00, "hold_pre");
    exp_at(6, S_SW, 8'h03, 8'h01, "hold_rise");
    tick(10); sw = 2'b00;
    tick(8);

    // Window contents follow I_top one cycle later.
    I_top = 16'h5555; exp_at(1, S_LED, 8'hFC, 8'hA8, "win_5555");
    tick(1);
    I_top = 16'h7E00; exp_at(1, S_LED, 8'hFC, 8'hFC, "win_7e00");
    tick(1);
    I_top = 16'hAAAA; exp_at(1, S_LED, 8'hFC, 8'h54, "win_aaaa");
    tick(2);

    // First button press.
    btn = 1'b1;
    exp_at(6,  S_PG,  8'hFF, 8'h00,  "page_pre");
    exp_at(7,  S_PG,  8'hFF, EXP_P1, "page_inc");
    exp_at(7,  S_LED, 8'hFC, 8'h54,  "win_pg_pre");
    exp_at(8,  S_LED, 8'hFC, EXP_W1, "win_pg1");
    exp_at(14, S_PG,  8'hFF, EXP_P1, "page_held");
    tick(10); btn = 1'b0;
    tick(10);

    // Configuration override with a press that must be discarded.
    com_active = 1'b1;
    exp_at(2, S_LED, 8'hFC, EXP_W1, "ovr_pre");
    for (int d = 3; d <= 10; d++)
      exp_at(d, S_LED, 8'hFC, hb_at(cyc + d) ? 8'hFC : 8'h00, "ovr_hb");
    exp_at(12, S_PG, 8'hFF, EXP_P1, "page_frozen");
    tick(2); btn = 1'b1;
    tick(8); btn = 1'b0;
    tick(12);
    com_active = 1'b0;
    exp_at(3, S_LED, 8'hFC, EXP_W1, "ovr_exit");
    exp_at(8, S_PG,  8'hFF, EXP_P1, "page_not_queued");
    tick(10);

    // Second press wraps the page.
    btn = 1'b1;
    exp_at(7, S_PG, 8'hFF, 8'h00, "page_wrap");
    tick(10); btn = 1'b0;
    tick(10);

    // Mid-operation reset aborts a partial debounce.
    while (cyc < rel_cyc + 80) tick(1);
    sw = 2'b11;
    tick(3);
    resetn = 1'b0;
    exp_at(1, S_LED, 8'hFF, 8'h00, "mrst_led");
    exp_at(1, S_SW,  8'h03, 8'h00, "mrst_sw");
    exp_at(1, S_PG,  8'hFF, 8'h00, "mrst_page");
    tick(2);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL mrst_led_direct actual=%h", led);
    end
    checks++;
    if (sw_db !== 2'b00) begin
      errors++;
      $display("FAIL mrst_sw_direct actual=%b", sw_db);
    end
    checks++;
    if (page !== 1'b0) begin
      errors++;
      $display("FAIL mrst_page_direct actual=%b", page);
    end
    resetn  = 1'b1;
    rel_cyc = cyc;
    exp_at(3, S_LED, 8'h01, 8'h00, "mrst_hb_lo");
    exp_at(4, S_LED, 8'h01, 8'h01, "mrst_hb_hi");
    exp_at(5, S_SW,  8'h03, 8'h00, "mrst_sw_pre");
    exp_at(6, S_SW,  8'h03, 8'h03, "mrst_sw_rise");

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    foreach (q[i]) begin
      errors++;
      $display("FAIL %s never_checked due_cyc=%0d now=%0d", q[i].name, q[i].cyc, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
